// File: rtl/inst_mem_loader.sv
// Boot-time instruction-memory loader: range-checks (address, word) beats and
// writes them to imem. Optional zero-fill sweep enabled by INST_MEM_LOADER_ZERO_FILL_EN.
module inst_mem_loader #(
  parameter int unsigned INST_SPACE = 1024,
  parameter logic [31:0] INST_START = 32'h0040_0000,
  parameter int unsigned IDX_W      = $clog2(INST_SPACE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_addr,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic             imem_we,
  output logic [IDX_W-1:0] imem_idx,
  output logic [31:0]      imem_wdata,
  output logic             cpu_rst,
  output logic [31:0]      boot_pc,
  output logic             done,
  output logic             error,
  output logic [31:0]      err_addr,
  output logic [IDX_W:0]   words_loaded
);

  localparam int unsigned LP_CW   = IDX_W + 1;
  localparam logic [32:0] LP_LO   = {1'b0, INST_START};
  localparam logic [32:0] LP_HI   = LP_LO + (33'(INST_SPACE) << 2);
  localparam logic [LP_CW-1:0] LP_MAXW = LP_CW'(INST_SPACE);

  typedef enum logic [1:0] {
`ifdef INST_MEM_LOADER_ZERO_FILL_EN
    S_CLEAR,
`endif
    S_LOAD,
    S_DONE,
    S_ERR
  } state_t;

`ifdef INST_MEM_LOADER_ZERO_FILL_EN
  localparam state_t LP_RST_STATE = S_CLEAR;
  logic [IDX_W-1:0] r_clr;
`else
  localparam state_t LP_RST_STATE = S_LOAD;
`endif

  state_t            r_state;
  logic              r_ready;
  logic              r_we;
  logic [IDX_W-1:0]  r_idx;
  logic [31:0]       r_wdata;
  logic              r_cpu_rst;
  logic [31:0]       r_boot_pc;
  logic              r_done;
  logic              r_err;
  logic [31:0]       r_err_addr;
  logic [LP_CW-1:0]  r_words;

  logic              w_accept;
  logic              w_aligned;
  logic              w_in_range;
  logic              w_has_room;
  logic              w_good;
  logic [IDX_W-1:0]  w_idx;

  // 33-bit compare keeps the window check free of wrap-around near 2^32
  assign w_accept   = in_valid && r_ready;
  assign w_aligned  = (in_addr[1:0] == 2'b00);
  assign w_in_range = ({1'b0, in_addr} >= LP_LO) && ({1'b0, in_addr} < LP_HI);
  assign w_has_room = (r_words < LP_MAXW);
  assign w_good     = w_aligned && w_in_range && w_has_room;
  assign w_idx      = IDX_W'((in_addr - INST_START) >> 2);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= LP_RST_STATE;
      r_ready    <= 1'b0;
      r_we       <= 1'b0;
      r_idx      <= '0;
      r_wdata    <= '0;
      r_cpu_rst  <= 1'b1;
      r_boot_pc  <= INST_START;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_err_addr <= '0;
      r_words    <= '0;
`ifdef INST_MEM_LOADER_ZERO_FILL_EN
      r_clr      <= '0;
`endif
    end else begin
      r_we <= 1'b0;
      case (r_state)
`ifdef INST_MEM_LOADER_ZERO_FILL_EN
        S_CLEAR: begin
          r_ready <= 1'b0;
          r_we    <= 1'b1;
          r_idx   <= r_clr;
          r_wdata <= '0;
          if (r_clr == IDX_W'(INST_SPACE - 1)) begin
            r_state <= S_LOAD;
          end else begin
            r_clr <= r_clr + 1'b1;
          end
        end
`endif
        S_LOAD: begin
          r_ready <= 1'b1;
          if (w_accept) begin
            if (w_good) begin
              r_we    <= 1'b1;
              r_idx   <= w_idx;
              r_wdata <= in_data;
              r_words <= r_words + 1'b1;
              if (r_words == '0) begin
                r_boot_pc <= in_addr;
              end
              if (in_last) begin
                r_state   <= S_DONE;
                r_ready   <= 1'b0;
                r_done    <= 1'b1;
                r_cpu_rst <= 1'b0;
              end
            end else begin
              r_state    <= S_ERR;
              r_ready    <= 1'b0;
              r_err      <= 1'b1;
              r_err_addr <= in_addr;
            end
          end
        end
        S_DONE:  r_ready <= 1'b0;
        S_ERR:   r_ready <= 1'b0;
        default: r_state <= S_ERR;
      endcase
    end
  end

  assign in_ready     = r_ready;
  assign imem_we      = r_we;
  assign imem_idx     = r_idx;
  assign imem_wdata   = r_wdata;
  assign cpu_rst      = r_cpu_rst;
  assign boot_pc      = r_boot_pc;
  assign done         = r_done;
  assign error        = r_err;
  assign err_addr     = r_err_addr;
  assign words_loaded = r_words;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed self-checking bench for inst_mem_loader (default parameters).
// Zero-fill sweep checks are compiled in with INST_MEM_LOADER_ZERO_FILL_EN.
module tb_inst_mem_loader;

  localparam int unsigned IDX_W = 10;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_addr;
  logic [31:0]      in_data;
  logic             in_last;
  logic             imem_we;
  logic [IDX_W-1:0] imem_idx;
  logic [31:0]      imem_wdata;
  logic             cpu_rst;
  logic [31:0]      boot_pc;
  logic             done;
  logic             error;
  logic [31:0]      err_addr;
  logic [IDX_W:0]   words_loaded;

  int n_checks = 0;
  int n_fails  = 0;

  inst_mem_loader dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data), .in_last(in_last),
    .imem_we(imem_we), .imem_idx(imem_idx), .imem_wdata(imem_wdata),
    .cpu_rst(cpu_rst), .boot_pc(boot_pc), .done(done), .error(error),
    .err_addr(err_addr), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, ".in_ready"},     64'(in_ready),     64'd0);
    chk({tag, ".imem_we"},      64'(imem_we),      64'd0);
    chk({tag, ".imem_idx"},     64'(imem_idx),     64'd0);
    chk({tag, ".imem_wdata"},   64'(imem_wdata),   64'd0);
    chk({tag, ".cpu_rst"},      64'(cpu_rst),      64'd1);
    chk({tag, ".boot_pc"},      64'(boot_pc),      64'h0040_0000);
    chk({tag, ".done"},         64'(done),         64'd0);
    chk({tag, ".error"},        64'(error),        64'd0);
    chk({tag, ".err_addr"},     64'(err_addr),     64'd0);
    chk({tag, ".words_loaded"}, 64'(words_loaded), 64'd0);
  endtask

  // Called with rst already sampled high; releases it and waits for LOAD.
  task automatic finish_reset(input string tag);
    rst = 1'b0;
`ifdef INST_MEM_LOADER_ZERO_FILL_EN
    for (int i = 0; i < 1024; i++) begin
      step();
      chk({tag, ".clr_ready"}, 64'(in_ready),   64'd0);
      chk({tag, ".clr_we"},    64'(imem_we),    64'd1);
      chk({tag, ".clr_wdata"}, 64'(imem_wdata), 64'd0);
      chk({tag, ".clr_idx"},   64'(imem_idx),   64'(i));
      chk({tag, ".clr_words"}, 64'(words_loaded), 64'd0);
    end
`endif
    step();
    chk({tag, ".ready_up"}, 64'(in_ready), 64'd1);
    chk({tag, ".cpu_rst_load"}, 64'(cpu_rst), 64'd1);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    in_valid = 1'b0;
    step();
    check_reset_vals(tag);
    finish_reset(tag);
  endtask

  task automatic beat(input logic [31:0] a, input logic [31:0] d, input logic l);
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    in_last  = l;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_addr = '0; in_data = '0; in_last = 1'b0;

    // Good 3-beat load
    do_reset("rst0");
    beat(32'h0040_0000, 32'h2408_0005, 1'b0);
    chk("g1.we", 64'(imem_we), 64'd1);
    chk("g1.idx", 64'(imem_idx), 64'd0);
    chk("g1.wdata", 64'(imem_wdata), 64'h2408_0005);
    chk("g1.cpu_rst", 64'(cpu_rst), 64'd1);
    beat(32'h0040_0004, 32'h2409_0007, 1'b0);
    chk("g2.idx", 64'(imem_idx), 64'd1);
    chk("g2.wdata", 64'(imem_wdata), 64'h2409_0007);
    chk("g2.done", 64'(done), 64'd0);
    beat(32'h0040_0008, 32'h0109_5020, 1'b1);
    chk("g3.we", 64'(imem_we), 64'd1);
    chk("g3.idx", 64'(imem_idx), 64'd2);
    chk("g3.wdata", 64'(imem_wdata), 64'h0109_5020);
    chk("g3.done", 64'(done), 64'd1);
    chk("g3.cpu_rst", 64'(cpu_rst), 64'd0);
    chk("g3.words", 64'(words_loaded), 64'd3);
    chk("g3.boot_pc", 64'(boot_pc), 64'h0040_0000);
    chk("g3.ready", 64'(in_ready), 64'd0);
    // beat offered in DONE is ignored
    beat(32'h0040_000C, 32'hDEAD_BEEF, 1'b0);
    chk("gd.we", 64'(imem_we), 64'd0);
    chk("gd.words", 64'(words_loaded), 64'd3);
    chk("gd.done", 64'(done), 64'd1);
    chk("gd.error", 64'(error), 64'd0);

    // Top word of the window is legal, one past it is not
    do_reset("rst1");
    beat(32'h0040_0FFC, 32'h1111_2222, 1'b0);
    chk("top.we", 64'(imem_we), 64'd1);
    chk("top.idx", 64'(imem_idx), 64'd1023);
    chk("top.boot_pc", 64'(boot_pc), 64'h0040_0FFC);
    beat(32'h0040_1000, 32'h3333_4444, 1'b1);
    chk("oor.we", 64'(imem_we), 64'd0);
    chk("oor.error", 64'(error), 64'd1);
    chk("oor.err_addr", 64'(err_addr), 64'h0040_1000);
    chk("oor.ready", 64'(in_ready), 64'd0);
    chk("oor.cpu_rst", 64'(cpu_rst), 64'd1);
    chk("oor.done", 64'(done), 64'd0);
    chk("oor.words", 64'(words_loaded), 64'd1);

    // Below the window
    do_reset("rst2");
    beat(32'h003F_FFFC, 32'h0, 1'b0);
    chk("low.error", 64'(error), 64'd1);
    chk("low.err_addr", 64'(err_addr), 64'h003F_FFFC);
    chk("low.we", 64'(imem_we), 64'd0);

    // Near 2^32: must not wrap into the window
    do_reset("rst3");
    beat(32'hFFFF_FFFC, 32'h0, 1'b0);
    chk("wrap.error", 64'(error), 64'd1);
    chk("wrap.err_addr", 64'(err_addr), 64'hFFFF_FFFC);

    // Misaligned last beat -> ERR, not DONE
    do_reset("rst4");
    beat(32'h0040_0006, 32'h0, 1'b1);
    chk("mis.error", 64'(error), 64'd1);
    chk("mis.done", 64'(done), 64'd0);
    chk("mis.err_addr", 64'(err_addr), 64'h0040_0006);
    chk("mis.cpu_rst", 64'(cpu_rst), 64'd1);
    chk("mis.we", 64'(imem_we), 64'd0);

    // Overflow: 1024 good beats then one more
    do_reset("rst5");
    for (int i = 0; i < 1024; i++) begin
      beat(32'h0040_0000 + 32'(i) * 4, 32'(i) ^ 32'hA5A5_0000, 1'b0);
      chk("ovf.we", 64'(imem_we), 64'd1);
      chk("ovf.idx", 64'(imem_idx), 64'(i));
    end
    chk("ovf.words_full", 64'(words_loaded), 64'd1024);
    chk("ovf.ready_full", 64'(in_ready), 64'd1);
    beat(32'h0040_0000, 32'h0, 1'b0);
    chk("ovf.error", 64'(error), 64'd1);
    chk("ovf.we_last", 64'(imem_we), 64'd0);
    chk("ovf.words", 64'(words_loaded), 64'd1024);
    chk("ovf.err_addr", 64'(err_addr), 64'h0040_0000);

    // Duplicate address: both beats counted, second data written
    do_reset("rst6");
    beat(32'h0040_0020, 32'h0000_0001, 1'b0);
    beat(32'h0040_0020, 32'h0000_0002, 1'b0);
    chk("dup.idx", 64'(imem_idx), 64'd8);
    chk("dup.wdata", 64'(imem_wdata), 64'd2);
    chk("dup.words", 64'(words_loaded), 64'd2);
    chk("dup.boot_pc", 64'(boot_pc), 64'h0040_0020);

    // Reset mid-load with a beat on the bus
    do_reset("rst7");
    beat(32'h0040_0000, 32'h0000_00AA, 1'b0);
    beat(32'h0040_0004, 32'h0000_00BB, 1'b0);
    chk("mid.words", 64'(words_loaded), 64'd2);
    in_valid = 1'b1;
    in_addr  = 32'h0040_0008;
    in_data  = 32'h0000_00CC;
    in_last  = 1'b0;
    rst      = 1'b1;
    step();
    check_reset_vals("mid");
    in_valid = 1'b0;
    finish_reset("mid");
    beat(32'h0040_0010, 32'h1234_5678, 1'b1);
    chk("rl.we", 64'(imem_we), 64'd1);
    chk("rl.idx", 64'(imem_idx), 64'd4);
    chk("rl.boot_pc", 64'(boot_pc), 64'h0040_0010);
    chk("rl.done", 64'(done), 64'd1);
    chk("rl.words", 64'(words_loaded), 64'd1);
    chk("rl.cpu_rst", 64'(cpu_rst), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
